// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - Shared types and default sizes for the block-copy engine.
package mem_copy_pkg;

  localparam int DEF_WORD     = 16;
  localparam int DEF_ADDRESSL = 10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  typedef enum logic {
    ASC,
    DESC
  } dir_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// rtl/mem_copy_addr_gen.sv - Source/destination pointers, remaining count and copy direction.
module mem_copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int ADDRESSL = DEF_ADDRESSL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                force_asc,
  input  logic                step,
  input  logic [ADDRESSL-1:0] src_addr,
  input  logic [ADDRESSL-1:0] dst_addr,
  input  logic [ADDRESSL:0]   count,
  output logic [ADDRESSL-1:0] cur_src,
  output logic [ADDRESSL-1:0] cur_dst,
  output logic                last
);

  logic [ADDRESSL-1:0] src_q, src_d;
  logic [ADDRESSL-1:0] dst_q, dst_d;
  logic [ADDRESSL:0]   remaining_q, remaining_d;
  dir_e                dir_q, dir_d;
  dir_e                start_dir;
  logic [ADDRESSL-1:0] gap;
  logic [ADDRESSL-1:0] span;

  always_comb begin
    gap  = dst_addr - src_addr;
    span = count[ADDRESSL-1:0] - ADDRESSL'(1);
    // A destination starting inside the source window must be filled from the top down.
    start_dir = ASC;
    if (!force_asc && (gap != '0) && ({1'b0, gap} < count)) begin
      start_dir = DESC;
    end

    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    if (load) begin
      dir_d       = start_dir;
      remaining_d = count;
      if (start_dir == DESC) begin
        src_d = src_addr + span;
        dst_d = dst_addr + span;
      end else begin
        src_d = src_addr;
        dst_d = dst_addr;
      end
    end else if (step) begin
      remaining_d = remaining_q - (ADDRESSL+1)'(1);
      if (dir_q == DESC) begin
        src_d = src_q - ADDRESSL'(1);
        dst_d = dst_q - ADDRESSL'(1);
      end else begin
        src_d = src_q + ADDRESSL'(1);
        dst_d = dst_q + ADDRESSL'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      dir_q       <= ASC;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
    end
  end

  assign cur_src = src_q;
  assign cur_dst = dst_q;
  assign last    = (remaining_q == (ADDRESSL+1)'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - Block-copy engine with memmove ordering on a single-port memory.
// Constant-fill mode (fillMode/fillData ports) is compiled in with MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int WORD     = DEF_WORD,
  parameter int LENGTH   = 1024,
  parameter int ADDRESSL = DEF_ADDRESSL
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [ADDRESSL-1:0] srcAddr,
  input  logic [ADDRESSL-1:0] dstAddr,
  input  logic [ADDRESSL:0]   count,
`ifdef MEM_COPY_FILL_EN
  input  logic                fillMode,
  input  logic [WORD-1:0]     fillData,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDRESSL-1:0] address,
  output logic [WORD-1:0]     writeData,
  input  logic [WORD-1:0]     readData,
  output logic                memRead,
  output logic                memWrite
);

  localparam logic [ADDRESSL:0] MAX_COUNT = (ADDRESSL+1)'(LENGTH);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDRESSL:0]   eff_count;
  logic                accept;
  logic                load;
  logic                step;
  logic                last;
  logic                start_fill;
  logic                fill_active;
  logic [WORD-1:0]     fill_word;
  logic [ADDRESSL-1:0] cur_src;
  logic [ADDRESSL-1:0] cur_dst;

`ifdef MEM_COPY_FILL_EN
  logic            fill_q, fill_d;
  logic [WORD-1:0] fill_data_q, fill_data_d;

  assign start_fill  = fillMode;
  assign fill_active = fill_q;
  assign fill_word   = fill_data_q;
`else
  assign start_fill  = 1'b0;
  assign fill_active = 1'b0;
  assign fill_word   = '0;
`endif

  // Out-of-range counts collapse to a whole-memory copy.
  assign eff_count = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign accept    = (state_q == IDLE) && start;
  assign load      = accept && (eff_count != '0);
  assign step      = (state_q == WRITE);

  mem_copy_addr_gen #(
    .ADDRESSL (ADDRESSL)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rstN),
    .load      (load),
    .force_asc (start_fill),
    .step      (step),
    .src_addr  (srcAddr),
    .dst_addr  (dstAddr),
    .count     (eff_count),
    .cur_src   (cur_src),
    .cur_dst   (cur_dst),
    .last      (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_count == '0)  state_d = DONE;
          else if (start_fill)  state_d = WRITE;
          else                  state_d = READ;
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = last ? DONE : (fill_active ? WRITE : READ);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == READ) || (state_d == WRITE);
    done_d = (state_d == DONE);
`ifdef MEM_COPY_FILL_EN
    fill_d      = accept ? fillMode : fill_q;
    fill_data_d = accept ? fillData : fill_data_q;
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_COPY_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MEM_COPY_FILL_EN
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
`endif
    end
  end

  // The word fetched in READ arrives on readData during the following WRITE.
  always_comb begin
    address   = '0;
    writeData = '0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    case (state_q)
      READ: begin
        address = cur_src;
        memRead = 1'b1;
      end
      WRITE: begin
        address   = cur_dst;
        memWrite  = 1'b1;
        writeData = fill_active ? fill_word : readData;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - Scoreboard bench for mem_copy_engine; fill test built with MEM_COPY_FILL_EN.
module tb_mem_copy_engine;

  localparam int W   = 16;
  localparam int AL  = 10;
  localparam int LEN = 1024;

  typedef struct packed {
    logic          wr;
    logic [AL-1:0] addr;
    logic [W-1:0]  data;
  } acc_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic [AL-1:0] srcAddr = '0;
  logic [AL-1:0] dstAddr = '0;
  logic [AL:0]   count = '0;
  logic          busy, done, memRead, memWrite;
  logic [AL-1:0] address;
  logic [W-1:0]  writeData;
  logic [W-1:0]  readData;
`ifdef MEM_COPY_FILL_EN
  logic          fillMode = 1'b0;
  logic [W-1:0]  fillData = '0;
`endif

  logic [W-1:0]  mem     [LEN];
  logic [W-1:0]  ref_mem [LEN];
  logic [W-1:0]  rd_q;
  logic          pl_en = 1'b0;
  logic [AL-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;

  acc_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .count     (count),
`ifdef MEM_COPY_FILL_EN
    .fillMode  (fillMode),
    .fillData  (fillData),
`endif
    .busy      (busy),
    .done      (done),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .memRead   (memRead),
    .memWrite  (memWrite)
  );

  always @(posedge clk) begin
    if (pl_en)    mem[pl_addr] <= pl_data;
    if (memRead)  rd_q <= mem[address];
    if (memWrite) mem[address] <= writeData;
  end
  assign readData = rd_q;

  task automatic poke(input logic [AL-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic model_copy(input logic [AL-1:0] src, input logic [AL-1:0] dst, input int cnt);
    logic [AL-1:0] gap, s, d;
    bit desc;
    gap  = dst - src;
    desc = (dst != src) && (int'(gap) < cnt);
    for (int i = 0; i < cnt; i++) begin
      s = desc ? src + AL'(cnt - 1 - i) : src + AL'(i);
      d = desc ? dst + AL'(cnt - 1 - i) : dst + AL'(i);
      exp_q.push_back(acc_t'{wr: 1'b0, addr: s, data: '0});
      ref_mem[d] = ref_mem[s];
      exp_q.push_back(acc_t'{wr: 1'b1, addr: d, data: ref_mem[d]});
    end
  endtask

  task automatic run_op(input string tag, input logic [AL-1:0] src, input logic [AL-1:0] dst,
                        input logic [AL:0] cnt, input int poke_cycle,
                        output int done_cyc, output int busy_cyc, output logic [AL-1:0] first_addr);
    acc_t e;
    bit   seen;
    seen       = 1'b0;
    first_addr = '0;
    done_cyc   = -1;
    busy_cyc   = 0;
    @(negedge clk);
    srcAddr = src;
    dstAddr = dst;
    count   = cnt;
    start   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke_cycle) begin
        start   = 1'b1;
        srcAddr = AL'(0);
        dstAddr = dst + AL'(1);
        count   = (AL+1)'(5);
      end
      if (busy) busy_cyc++;
      n_cmp++;
      if (memRead && memWrite) begin
        n_bad++;
        $display("FAIL %s_port_exclusive cycle %0d: got memRead=1 memWrite=1, required at most one", tag, c);
      end
      if (memRead || memWrite) begin
        if (!seen) first_addr = address;
        seen = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s_access cycle %0d: got wr=%b addr=%0d, required no access", tag, c, memWrite, address);
        end else begin
          e = exp_q.pop_front();
          if (memWrite !== e.wr || address !== e.addr || (e.wr && writeData !== e.data)) begin
            n_bad++;
            $display("FAIL %s_access cycle %0d: got wr=%b addr=%0d data=%h, required wr=%b addr=%0d data=%h",
                     tag, c, memWrite, address, writeData, e.wr, e.addr, e.data);
          end
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got no done within 200 cycles, required a done pulse", tag);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_leftover: got %0d accesses missing, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_width: got done=%b busy=%b after pulse, required 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, memRead, memWrite} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 0000", {busy, done, memRead, memWrite});
    end
    n_cmp++;
    if (address !== '0 || writeData !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%0d data=%h, required 0 0", address, writeData);
    end
    rstN = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0]  want [4];
    logic [AL-1:0] fa;
    int dc, bc;
    want = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    for (int i = 0; i < 4; i++) begin
      poke(AL'(16 + i), want[i]);
      poke(AL'(100 + i), 16'h0000);
    end
    model_copy(AL'(16), AL'(100), 4);
    run_op("basic", AL'(16), AL'(100), (AL+1)'(4), 0, dc, bc, fa);
    n_cmp++;
    if (dc !== 9) begin n_bad++; $display("FAIL basic_done_cycle: got %0d, required 9", dc); end
    n_cmp++;
    if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d, required 8", bc); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[AL'(100 + i)] !== want[i]) begin
        n_bad++;
        $display("FAIL basic_mem[%0d]: got %h, required %h", 100 + i, mem[AL'(100 + i)], want[i]);
      end
    end
  endtask

  task automatic test_overlap(input string tag, input int src, input int dst, input int first);
    logic [AL-1:0] fa;
    int dc, bc;
    for (int i = 0; i < 6; i++) poke(AL'(10 + i), 16'h0000);
    for (int i = 0; i < 4; i++) poke(AL'(src + i), W'(i + 1));
    model_copy(AL'(src), AL'(dst), 4);
    run_op(tag, AL'(src), AL'(dst), (AL+1)'(4), 0, dc, bc, fa);
    n_cmp++;
    if (fa !== AL'(first)) begin n_bad++; $display("FAIL %s_first_addr: got %0d, required %0d", tag, fa, first); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[AL'(dst + i)] !== W'(i + 1)) begin
        n_bad++;
        $display("FAIL %s_mem[%0d]: got %h, required %h", tag, dst + i, mem[AL'(dst + i)], W'(i + 1));
      end
    end
  endtask

  task automatic test_wrap();
    logic [AL-1:0] fa;
    int dc, bc;
    for (int i = 0; i < 4; i++) begin
      poke(AL'(1022 + i), W'(16'h5A00 + i));
      poke(AL'(5 + i), 16'h0000);
    end
    model_copy(AL'(1022), AL'(5), 4);
    run_op("wrap", AL'(1022), AL'(5), (AL+1)'(4), 0, dc, bc, fa);
    n_cmp++;
    if (fa !== AL'(1022)) begin n_bad++; $display("FAIL wrap_first_addr: got %0d, required 1022", fa); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[AL'(5 + i)] !== W'(16'h5A00 + i)) begin
        n_bad++;
        $display("FAIL wrap_mem[%0d]: got %h, required %h", 5 + i, mem[AL'(5 + i)], W'(16'h5A00 + i));
      end
    end
  endtask

  task automatic test_zero_count();
    logic [AL-1:0] fa;
    int dc, bc;
    run_op("zero", AL'(3), AL'(50), (AL+1)'(0), 0, dc, bc, fa);
    n_cmp++;
    if (dc !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d, required 1", dc); end
    n_cmp++;
    if (bc !== 0) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d, required 0", bc); end
  endtask

  task automatic test_busy_ignore();
    logic [AL-1:0] fa;
    int dc, bc;
    for (int i = 0; i < 3; i++) begin
      poke(AL'(40 + i), W'(16'h7700 + i));
      poke(AL'(60 + i), 16'h0000);
    end
    model_copy(AL'(40), AL'(60), 3);
    run_op("ignore", AL'(40), AL'(60), (AL+1)'(3), 3, dc, bc, fa);
    n_cmp++;
    if (dc !== 7) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d, required 7", dc); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[AL'(60 + i)] !== W'(16'h7700 + i)) begin
        n_bad++;
        $display("FAIL ignore_mem[%0d]: got %h, required %h", 60 + i, mem[AL'(60 + i)], W'(16'h7700 + i));
      end
    end
  endtask

  task automatic test_same_addr();
    logic [AL-1:0] fa;
    int dc, bc;
    for (int i = 0; i < 3; i++) poke(AL'(70 + i), W'(16'h3300 + i));
    model_copy(AL'(70), AL'(70), 3);
    run_op("same", AL'(70), AL'(70), (AL+1)'(3), 0, dc, bc, fa);
    n_cmp++;
    if (dc !== 7) begin n_bad++; $display("FAIL same_done_cycle: got %0d, required 7", dc); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[AL'(70 + i)] !== W'(16'h3300 + i)) begin
        n_bad++;
        $display("FAIL same_mem[%0d]: got %h, required %h", 70 + i, mem[AL'(70 + i)], W'(16'h3300 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0]  want [4];
    logic [AL-1:0] fa;
    int dc, bc;
    want = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      poke(AL'(300 + i), W'(16'h1111 * (i + 1)));
      poke(AL'(400 + i), 16'h0000);
    end
    @(negedge clk);
    srcAddr = AL'(300);
    dstAddr = AL'(400);
    count   = (AL+1)'(4);
    start   = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (memWrite !== 1'b1 || address !== AL'(401)) begin
      n_bad++;
      $display("FAIL rmid_in_write2: got memWrite=%b addr=%0d, required 1 401", memWrite, address);
    end
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, memRead, memWrite} !== 4'b0000 || address !== '0 || writeData !== '0) begin
      n_bad++;
      $display("FAIL rmid_outputs: got flags=%b addr=%0d data=%h, required 0000 0 0",
               {busy, done, memRead, memWrite}, address, writeData);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rmid_quiet cycle %0d: got done=%b busy=%b, required 0 0", c, done, busy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[AL'(400 + i)] !== want[i]) begin
        n_bad++;
        $display("FAIL rmid_mem[%0d]: got %h, required %h", 400 + i, mem[AL'(400 + i)], want[i]);
      end
    end
    for (int i = 0; i < 2; i++) poke(AL'(500 + i), 16'h0000);
    model_copy(AL'(300), AL'(500), 2);
    run_op("recover", AL'(300), AL'(500), (AL+1)'(2), 0, dc, bc, fa);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("FAIL recover_done_cycle: got %0d, required 5", dc); end
  endtask

`ifdef MEM_COPY_FILL_EN
  task automatic test_fill();
    logic [AL-1:0] fa;
    int dc, bc;
    for (int i = 0; i < 3; i++) poke(AL'(200 + i), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(acc_t'{wr: 1'b1, addr: AL'(200 + i), data: 16'hBEEF});
      ref_mem[AL'(200 + i)] = 16'hBEEF;
    end
    fillMode = 1'b1;
    fillData = 16'hBEEF;
    run_op("fill", AL'(7), AL'(200), (AL+1)'(3), 0, dc, bc, fa);
    fillMode = 1'b0;
    n_cmp++;
    if (dc !== 4) begin n_bad++; $display("FAIL fill_done_cycle: got %0d, required 4", dc); end
    n_cmp++;
    if (bc !== 3) begin n_bad++; $display("FAIL fill_busy_cycles: got %0d, required 3", bc); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[AL'(200 + i)] !== 16'hBEEF) begin
        n_bad++;
        $display("FAIL fill_mem[%0d]: got %h, required beef", 200 + i, mem[AL'(200 + i)]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overlap("ovl_fwd", 10, 12, 13);
    test_overlap("ovl_back", 12, 10, 12);
    test_wrap();
    test_zero_count();
    test_busy_ignore();
    test_same_addr();
    test_reset_mid();
`ifdef MEM_COPY_FILL_EN
    test_fill();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
